// File: rtl/bch_chien_search_pkg.sv
// Shared GF(2^m) definitions for the BCH decoder stages.
// Provides field sizes, the field types and the constant multiply helpers.
package bch_chien_search_pkg;

  localparam int m      = 4;
  localparam int k_max  = 5;
  localparam int d      = 7;
  localparam int irrpol = 19;
  localparam int t      = (d - 1) / 2;
  localparam int t2     = 2 * t;
  localparam int N      = (1 << m) - 1;
  localparam int cCNT_W = $clog2(t + 1);
  localparam int cPTR_W = 2;

  typedef logic [m-1:0]      data_t;
  typedef logic [cPTR_W-1:0] ptr_t;
  typedef logic [cCNT_W-1:0] cnt_t;

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_RUN} state_t;

  // Low m bits of the primitive polynomial; x^m is implied by the shift-out.
  localparam data_t cIRR_LOW = data_t'(irrpol);

  function automatic data_t gf_mult_a_by_b(input data_t a, input data_t b);
    data_t acc;
    data_t sh;
    acc = '0;
    sh  = a;
    for (int i = 0; i < m; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = {sh[m-2:0], 1'b0} ^ (sh[m-1] ? cIRR_LOW : '0);
    end
    return acc;
  endfunction

  function automatic data_t alpha_pow(input int e);
    data_t r;
    r = data_t'(1);
    for (int i = 0; i < (e % N); i++) r = gf_mult_a_by_b(r, data_t'(2));
    return r;
  endfunction

endpackage

// File: rtl/bch_chien_cell.sv
// One Chien term register: loads Lambda_j scaled to the first position,
// then steps by alpha^J on every beat.
module bch_chien_cell
  import bch_chien_search_pkg::*;
#(
  parameter int J        = 0,
  parameter int LOAD_EXP = 1
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_clkena,
  input  logic         i_load,
  input  logic         i_step,
  input  logic [m-1:0] i_coef,
  output logic [m-1:0] o_val
);

  localparam data_t cLOAD_K = alpha_pow(J * LOAD_EXP);
  localparam data_t cSTEP_K = alpha_pow(J);

  logic [m-1:0] r_val;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_val <= '0;
    end else if (i_clkena) begin
      if (i_load)      r_val <= gf_mult_a_by_b(i_coef, cLOAD_K);
      else if (i_step) r_val <= gf_mult_a_by_b(r_val, cSTEP_K);
    end
  end

  assign o_val = r_val;

endmodule

// File: rtl/bch_chien_search.sv
// Serial Chien search: one codeword position per beat from p=n-1 down to 0,
// with a one-deep shadow buffer so frames can stream with a single bubble.
module bch_chien_search
  import bch_chien_search_pkg::*;
#(
  parameter int n = N
) (
  input  logic              iclk,
  input  logic              ireset,
  input  logic              iclkena,
  input  logic              iloc_poly_val,
  input  logic [m-1:0]      iloc_poly [0:t],
  input  logic [cPTR_W-1:0] iloc_poly_ptr,
  output logic              oval,
  output logic              osop,
  output logic              oeop,
  output logic              oerr,
  output logic [cPTR_W-1:0] optr,
  output logic [cCNT_W-1:0] oerr_num,
  output logic              odecfail,
  output logic              ooverflow
);

  localparam int                 cBEAT_W    = $clog2(n + 1);
  localparam logic [cBEAT_W-1:0] cBEAT_LAST = cBEAT_W'(n - 1);
  localparam cnt_t               cT_CNT     = cnt_t'(t);

  state_t             r_state;
  state_t             w_state_next;
  data_t              r_wrk_poly [0:t];
  data_t              r_sh_poly  [0:t];
  ptr_t               r_wrk_ptr;
  ptr_t               r_sh_ptr;
  ptr_t               r_ptr;
  logic               r_sh_vld;
  logic               r_ovf;
  logic               r_lam0_zero;
  cnt_t               r_cnt;
  cnt_t               r_deg;
  cnt_t               w_deg;
  cnt_t               w_cnt_next;
  logic [cBEAT_W-1:0] r_beat;
  logic               w_run;
  logic               w_load;
  logic               w_last;
  logic               w_wrk_from_in;
  logic               w_wrk_from_sh;
  logic               w_sh_from_in;
  logic               w_sh_clr;
  logic               w_ovf_set;
  data_t              w_cell [0:t];
  data_t              w_acc  [0:t+1];

  assign w_run  = (r_state == ST_RUN);
  assign w_load = (r_state == ST_LOAD);
  assign w_last = w_run && (r_beat == '0);

  always_ff @(posedge iclk or negedge ireset) begin
    if (!ireset)      r_state <= ST_IDLE;
    else if (iclkena) r_state <= w_state_next;
  end

  // A strobe on the last beat is routed like a shadow load and consumed at once.
  always_comb begin
    w_state_next  = r_state;
    w_wrk_from_in = 1'b0;
    w_wrk_from_sh = 1'b0;
    w_sh_from_in  = 1'b0;
    w_sh_clr      = 1'b0;
    w_ovf_set     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (iloc_poly_val) begin
          w_state_next  = ST_LOAD;
          w_wrk_from_in = 1'b1;
        end
      end
      ST_LOAD: begin
        w_state_next = ST_RUN;
        if (iloc_poly_val) begin
          if (r_sh_vld) w_ovf_set    = 1'b1;
          else          w_sh_from_in = 1'b1;
        end
      end
      ST_RUN: begin
        if (w_last) begin
          if (r_sh_vld) begin
            w_state_next  = ST_LOAD;
            w_wrk_from_sh = 1'b1;
            if (iloc_poly_val) w_sh_from_in = 1'b1;
            else               w_sh_clr     = 1'b1;
          end else if (iloc_poly_val) begin
            w_state_next  = ST_LOAD;
            w_wrk_from_in = 1'b1;
          end else begin
            w_state_next = ST_IDLE;
          end
        end else if (iloc_poly_val) begin
          if (r_sh_vld) w_ovf_set    = 1'b1;
          else          w_sh_from_in = 1'b1;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_deg = '0;
    for (int j = 1; j <= t; j++) begin
      if (r_wrk_poly[j] != '0) w_deg = cnt_t'(j);
    end
  end

  always_ff @(posedge iclk or negedge ireset) begin
    if (!ireset) begin
      for (int j = 0; j <= t; j++) begin
        r_wrk_poly[j] <= '0;
        r_sh_poly[j]  <= '0;
      end
      r_wrk_ptr   <= '0;
      r_sh_ptr    <= '0;
      r_sh_vld    <= 1'b0;
      r_ovf       <= 1'b0;
      r_ptr       <= '0;
      r_deg       <= '0;
      r_lam0_zero <= 1'b0;
      r_cnt       <= '0;
      r_beat      <= '0;
    end else if (iclkena) begin
      if (w_wrk_from_in) begin
        r_wrk_poly <= iloc_poly;
        r_wrk_ptr  <= iloc_poly_ptr;
      end else if (w_wrk_from_sh) begin
        r_wrk_poly <= r_sh_poly;
        r_wrk_ptr  <= r_sh_ptr;
      end
      if (w_sh_from_in) begin
        r_sh_poly <= iloc_poly;
        r_sh_ptr  <= iloc_poly_ptr;
        r_sh_vld  <= 1'b1;
      end else if (w_sh_clr) begin
        r_sh_vld <= 1'b0;
      end
      if (w_ovf_set) r_ovf <= 1'b1;
      if (w_load) begin
        r_ptr       <= r_wrk_ptr;
        r_deg       <= w_deg;
        r_lam0_zero <= (r_wrk_poly[0] == '0);
        r_cnt       <= '0;
        r_beat      <= cBEAT_LAST;
      end else if (w_run) begin
        r_cnt <= w_cnt_next;
        if (!w_last) r_beat <= r_beat - 1'b1;
      end
    end
  end

  assign w_acc[0] = '0;

  for (genvar gi = 0; gi <= t; gi++) begin : g_cell
    bch_chien_cell #(
      .J        (gi),
      .LOAD_EXP (N - n + 1)
    ) u_cell (
      .i_clk    (iclk),
      .i_rst_n  (ireset),
      .i_clkena (iclkena),
      .i_load   (w_load),
      .i_step   (w_run),
      .i_coef   (r_wrk_poly[gi]),
      .o_val    (w_cell[gi])
    );
    assign w_acc[gi+1] = w_acc[gi] ^ w_cell[gi];
  end

  // Count includes the current beat so the final value is ready on oeop.
  assign w_cnt_next = (oerr && (r_cnt != cT_CNT)) ? r_cnt + 1'b1 : r_cnt;

  assign oval      = w_run;
  assign osop      = w_run && (r_beat == cBEAT_LAST);
  assign oeop      = w_last;
  assign oerr      = w_run && (w_acc[t+1] == '0);
  assign optr      = w_run ? r_ptr : '0;
  assign oerr_num  = w_last ? w_cnt_next : '0;
  assign odecfail  = w_last && (r_lam0_zero || (w_cnt_next != r_deg));
  assign ooverflow = r_ovf;

endmodule

// File: tb/tb_bch_chien_search.sv
// Directed bench for the Chien search stage: table-driven frames on n=15 and
// n=10 instances, plus overflow, clock-enable and mid-frame reset sequences.
module tb_bch_chien_search;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clkena;
  logic       val15;
  logic       val10;
  logic [3:0] loc_poly [0:3];
  logic [1:0] loc_ptr;

  logic       o15_val, o15_sop, o15_eop, o15_err, o15_fail, o15_ovf;
  logic [1:0] o15_ptr, o15_num;
  logic       o10_val, o10_sop, o10_eop, o10_err, o10_fail, o10_ovf;
  logic [1:0] o10_ptr, o10_num;

  logic       sel;
  logic       s_val, s_sop, s_eop, s_err, s_fail;
  logic [1:0] s_ptr, s_num;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic        sel10;
    logic [15:0] poly;
    logic [1:0]  ptr;
    logic [15:0] mask;
    logic [1:0]  num;
    logic        fail;
  } vec_t;

  vec_t vecs [0:5];

  always #5 clk = ~clk;

  bch_chien_search #(.n(15)) u_dut15 (
    .iclk(clk), .ireset(rst_n), .iclkena(clkena), .iloc_poly_val(val15),
    .iloc_poly(loc_poly), .iloc_poly_ptr(loc_ptr),
    .oval(o15_val), .osop(o15_sop), .oeop(o15_eop), .oerr(o15_err),
    .optr(o15_ptr), .oerr_num(o15_num), .odecfail(o15_fail), .ooverflow(o15_ovf)
  );

  bch_chien_search #(.n(10)) u_dut10 (
    .iclk(clk), .ireset(rst_n), .iclkena(clkena), .iloc_poly_val(val10),
    .iloc_poly(loc_poly), .iloc_poly_ptr(loc_ptr),
    .oval(o10_val), .osop(o10_sop), .oeop(o10_eop), .oerr(o10_err),
    .optr(o10_ptr), .oerr_num(o10_num), .odecfail(o10_fail), .ooverflow(o10_ovf)
  );

  assign s_val  = sel ? o10_val  : o15_val;
  assign s_sop  = sel ? o10_sop  : o15_sop;
  assign s_eop  = sel ? o10_eop  : o15_eop;
  assign s_err  = sel ? o10_err  : o15_err;
  assign s_fail = sel ? o10_fail : o15_fail;
  assign s_ptr  = sel ? o10_ptr  : o15_ptr;
  assign s_num  = sel ? o10_num  : o15_num;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
  endtask

  task automatic set_poly(input logic [15:0] p);
    for (int j = 0; j < 4; j++) loc_poly[j] = p[4*j +: 4];
  endtask

  // Call just after a rising edge; returns just after a rising edge.
  task automatic run_vec(input string tag, input int idx);
    vec_t        v;
    int          nn;
    logic [63:0] val_m, sop_m, eop_m;
    logic [15:0] err_m;
    logic [1:0]  num, ptr;
    logic        fail;
    v     = vecs[idx];
    nn    = v.sel10 ? 10 : 15;
    sel   = v.sel10;
    val_m = '0; sop_m = '0; eop_m = '0; err_m = '0;
    num   = 2'd0; ptr = 2'd0; fail = 1'b0;
    set_poly(v.poly);
    loc_ptr = v.ptr;
    if (v.sel10) val10 = 1'b1;
    else         val15 = 1'b1;
    @(posedge clk); #1;
    val15 = 1'b0;
    val10 = 1'b0;
    for (int c = 1; c <= nn + 2; c++) begin
      @(negedge clk);
      val_m[c] = s_val;
      sop_m[c] = s_sop;
      eop_m[c] = s_eop;
      if (s_val && c >= 2) err_m[c-2] = s_err;
      if (s_sop) ptr = s_ptr;
      if (s_eop) begin
        num  = s_num;
        fail = s_fail;
      end
    end
    chk($sformatf("%s%0d_val", tag, idx), val_m, ((64'd1 << nn) - 64'd1) << 2);
    chk($sformatf("%s%0d_sop", tag, idx), sop_m, 64'd1 << 2);
    chk($sformatf("%s%0d_eop", tag, idx), eop_m, 64'd1 << (nn + 1));
    chk($sformatf("%s%0d_err", tag, idx), {48'd0, err_m}, {48'd0, v.mask});
    chk($sformatf("%s%0d_num", tag, idx), {62'd0, num}, {62'd0, v.num});
    chk($sformatf("%s%0d_fail", tag, idx), {63'd0, fail}, {63'd0, v.fail});
    chk($sformatf("%s%0d_ptr", tag, idx), {62'd0, ptr}, {62'd0, v.ptr});
    @(posedge clk); #1;
  endtask

  initial begin
    logic [63:0] vm, sm, em, errm;
    logic [1:0]  ptr_a, ptr_b, num_a, num_b;
    logic        fail_b, ovf2, ovf3;
    int          cnt_v, cnt_e, cnt_err, eop_at;

    sel = 1'b0; rst_n = 1'b0; clkena = 1'b1; val15 = 1'b0; val10 = 1'b0; loc_ptr = 2'd0;
    set_poly(16'h0000);

    // sel10, {L3,L2,L1,L0}, ptr, error-beat mask, oerr_num, odecfail
    vecs[0] = '{1'b0, 16'h0001, 2'd1, 16'h0000, 2'd0, 1'b0};  // no roots
    vecs[1] = '{1'b0, 16'h0061, 2'd2, 16'h0200, 2'd1, 1'b0};  // 1+a^5 x: p=5
    vecs[2] = '{1'b0, 16'h0981, 2'd3, 16'h4001, 2'd2, 1'b0};  // (1+a^14 x)(1+x)
    vecs[3] = '{1'b1, 16'h00F1, 2'd0, 16'h0000, 2'd0, 1'b1};  // n=10, root at p=12
    vecs[4] = '{1'b0, 16'h0010, 2'd1, 16'h0000, 2'd0, 1'b1};  // L0 == 0
    vecs[5] = '{1'b0, 16'h0111, 2'd2, 16'h0210, 2'd2, 1'b0};  // 1+x+x^2: p=10,5

    repeat (3) @(negedge clk);
    chk("rst_out15", {54'd0, o15_val, o15_sop, o15_eop, o15_err, o15_ptr, o15_num, o15_fail, o15_ovf}, 64'd0);
    chk("rst_out10", {54'd0, o10_val, o10_sop, o10_eop, o10_err, o10_ptr, o10_num, o10_fail, o10_ovf}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_out15", {54'd0, o15_val, o15_sop, o15_eop, o15_err, o15_ptr, o15_num, o15_fail, o15_ovf}, 64'd0);
    @(posedge clk); #1;

    for (int i = 0; i <= 5; i++) run_vec("v", i);

    // Three strobes back to back: A runs, B waits in the shadow, C is dropped.
    sel = 1'b0;
    vm = '0; sm = '0; em = '0; errm = '0;
    ptr_a = 2'd0; ptr_b = 2'd0; num_a = 2'd0; num_b = 2'd3; fail_b = 1'b1; ovf2 = 1'b1; ovf3 = 1'b0;
    set_poly(16'h0061); loc_ptr = 2'd1; val15 = 1'b1;
    @(posedge clk); #1;
    for (int c = 1; c <= 36; c++) begin
      if (c == 1)      begin set_poly(16'h0001); loc_ptr = 2'd2; end
      else if (c == 2) begin set_poly(16'h0011); loc_ptr = 2'd3; end
      else             val15 = 1'b0;
      @(negedge clk);
      vm[c] = o15_val; sm[c] = o15_sop; em[c] = o15_eop; errm[c] = o15_err;
      if (c == 2)  begin ptr_a = o15_ptr; ovf2 = o15_ovf; end
      if (c == 3)  ovf3 = o15_ovf;
      if (c == 16) num_a = o15_num;
      if (c == 18) ptr_b = o15_ptr;
      if (c == 32) begin num_b = o15_num; fail_b = o15_fail; end
      @(posedge clk); #1;
    end
    chk("ov_val", vm, (((64'd1 << 15) - 64'd1) << 2) | (((64'd1 << 15) - 64'd1) << 18));
    chk("ov_sop", sm, (64'd1 << 2) | (64'd1 << 18));
    chk("ov_eop", em, (64'd1 << 16) | (64'd1 << 32));
    chk("ov_err", errm, 64'd1 << 11);
    chk("ov_ptr_a", {62'd0, ptr_a}, 64'd1);
    chk("ov_ptr_b", {62'd0, ptr_b}, 64'd2);
    chk("ov_num_a", {62'd0, num_a}, 64'd1);
    chk("ov_eop_b", {61'd0, num_b, fail_b}, 64'd0);
    chk("ov_flag_pre", {63'd0, ovf2}, 64'd0);
    chk("ov_flag_set", {63'd0, ovf3}, 64'd1);
    chk("ov_flag_hold", {63'd0, o15_ovf}, 64'd1);

    // Strobe while the clock enable is low must be ignored.
    clkena = 1'b0; set_poly(16'h0001); loc_ptr = 2'd1; val15 = 1'b1;
    @(posedge clk); #1;
    val15 = 1'b0; clkena = 1'b1;
    cnt_v = 0;
    repeat (20) begin
      @(negedge clk);
      cnt_v += int'(o15_val);
    end
    chk("ena_ignore", cnt_v, 0);
    @(posedge clk); #1;

    // Freeze a running frame for three cycles: beat count stretches by three.
    set_poly(16'h0001); loc_ptr = 2'd1; val15 = 1'b1;
    @(posedge clk); #1;
    val15 = 1'b0;
    cnt_v = 0; cnt_err = 0; eop_at = 0;
    for (int c = 1; c <= 25; c++) begin
      clkena = !(c >= 5 && c <= 7);
      @(negedge clk);
      cnt_v   += int'(o15_val);
      cnt_err += int'(o15_err);
      if (o15_eop) eop_at = c;
      @(posedge clk); #1;
    end
    clkena = 1'b1;
    chk("frz_val", cnt_v, 18);
    chk("frz_eop", eop_at, 19);
    chk("frz_err", cnt_err, 0);

    // Reset at beat 5 with a second frame waiting in the shadow.
    set_poly(16'h0001); loc_ptr = 2'd1; val15 = 1'b1;
    @(posedge clk); #1;
    set_poly(16'h0061); loc_ptr = 2'd2;
    cnt_e = 0;
    for (int c = 1; c <= 7; c++) begin
      if (c == 2) val15 = 1'b0;
      @(negedge clk);
      cnt_e += int'(o15_eop);
      if (c != 7) begin
        @(posedge clk); #1;
      end
    end
    chk("rst_mid_pre", {63'd0, o15_val}, 64'd1);
    #1 rst_n = 1'b0;
    #1 chk("rst_mid_out", {54'd0, o15_val, o15_sop, o15_eop, o15_err, o15_ptr, o15_num, o15_fail, o15_ovf}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cnt_v = 0;
    repeat (40) begin
      @(negedge clk);
      cnt_v += int'(o15_val);
      cnt_e += int'(o15_eop);
    end
    chk("rst_no_out", cnt_v, 0);
    chk("rst_no_eop", cnt_e, 0);
    @(posedge clk); #1;

    run_vec("post", 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/bch_chien_search.md
Name: bch_chien_search

Overview:
Serial Chien search stage placed directly downstream of the inversionless Berlekamp block. It takes the error-locator polynomial Λ(x)[0:t] and evaluates Λ(α^-p) for each codeword position p, one position per clock. It emits one error flag per position, in codeword order from p=n-1 down to p=0. At frame end it reports the root count and a decoder-failure flag for the error-correction stage.

Parameters:
m, 4, GF(2^m) symbol width
k_max, 5, maximum information length (shared bch_parameters)
d, 7, code distance; t=(d-1)/2 derived
n, 15, codeword length; shortened codes have n < 2^m-1
irrpol, 19, field primitive polynomial

Ports:
iclk  in  1  clock
ireset  in  1  asynchronous reset, active-low
iclkena  in  1  clock enable; all state holds when low
iloc_poly_val  in  1  Λ strobe, single-cycle
iloc_poly  in  data_t[0:t]  Λ coefficients, Λ0 at index 0
iloc_poly_ptr  in  ptr_t  buffer pointer tied to this Λ
oval  out  1  output beat valid
osop  out  1  first beat of a frame (p=n-1)
oeop  out  1  last beat of a frame (p=0)
oerr  out  1  Λ(α^-p)==0 at this beat
optr  out  ptr_t  pointer of the frame being output
oerr_num  out  cCNT_W  roots found; valid on oeop
odecfail  out  1  failure flag; valid on oeop
ooverflow  out  1  sticky: Λ lost because both buffers were full

Behaviour:
- Reset values: all outputs 0. FSM goes to IDLE, both buffer-valid flags clear, root counter 0, ooverflow 0.
- Input side has no backpressure. A 1-deep shadow register (Λ, ptr) absorbs one Λ that arrives while a frame is running.
  - iloc_poly_val in IDLE: Λ goes to the working set.
  - iloc_poly_val while busy and shadow empty: Λ goes to the shadow.
  - iloc_poly_val while busy and shadow full: Λ is dropped and ooverflow is set. It clears only on reset.
- FSM states: IDLE, LOAD, RUN.
  - IDLE -> LOAD on capture.
  - LOAD (1 cycle): reg[j] <= Λj·α^(j·(N-n+1) mod N), with N=2^m-1 (constant multipliers). Also computes deg = highest j with Λj≠0, clears the root counter, latches ptr.
  - RUN (n cycles): each beat evaluates sum_j reg[j]. oerr=1 iff the sum is 0. Then reg[j] <= reg[j]·α^j. A beat counter runs n-1 down to 0.
  - RUN -> LOAD on the last beat if the shadow is valid or a Λ arrives that same cycle. The shadow moves to the working set, so frames stream back-to-back with one bubble. Otherwise RUN -> IDLE.
- Latency: strobe at cycle k gives osop/oval at k+2 and oeop at k+n+1. oval stays high for exactly n consecutive enabled cycles per frame.
- oerr_num = number of oerr beats in the frame, saturating at t.
- odecfail = 1 if any of the following holds; otherwise 0:
  - Λ0==0, or
  - deg > t, or
  - root count ≠ deg. This catches roots lying in shortened positions p ≥ n, or Λ without a full root set.
- Simultaneous last RUN beat and new strobe: the strobe is treated as a shadow load and consumed immediately. No overflow is flagged.
- Reset mid-frame: the frame is aborted, no oeop is produced, buffered Λ is discarded.
- iclkena low freezes everything. Input strobes presented while iclkena is low are ignored.
- All field arithmetic uses the gf_mult_a_by_b and α-power helpers from the shared function include. No full inversion is required.

Decomposition:
- Shared package/include: data_t, ptr_t, t, t2, N, cCNT_W, and the α-power constant table function (alpha_pow(e) mod N). These are reused by syndrome and Berlekamp stages.
- One natural sub-module: bch_chien_cell. It holds one reg[j], applies the load-time constant multiply and the per-beat α^j multiply. The top generates t+1 of them plus the XOR adder tree.

Test Plan (m=4, irrpol=19, d=7, t=3, α=2):
- Λ={1,0,0,0}, n=15 -> 15 beats, osop on beat 0, oeop on beat 14, oerr never, oerr_num=0, odecfail=0.
- Λ={1,α^5,0,0}, n=15 -> oerr only on beat 9 (p=5); oerr_num=1, odecfail=0.
- Λ=(1+α^14x)(1+x), n=15 -> oerr on beat 0 (p=14) and beat 14 (p=0); oerr_num=2, odecfail=0.
- n=10, Λ={1,α^12,0,0} -> no oerr in 10 beats; oerr_num=0, odecfail=1 (root in shortened region).
- Three strobes at cycles 0, 1, 2 -> frame A output, frame B starts after one bubble with optr=B, frame C dropped, ooverflow=1 and stays high.
- ireset low at beat 5 of a frame -> all outputs 0 next cycle, no oeop; after release, a fresh Λ={1,α^5,0,0} gives the correct result from the single-error case.
